// File: rtl/dsram_arb.sv
// dsram_arb: shares the single-port data SRAM between the core (C) and DMA (D) ports.
// Optional starvation guard for D is built in when DSRAM_ARB_STARVE_EN is defined.
module dsram_arb #(
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned AW       = 32
) (
    input  logic          clk,
    input  logic          cpurst_n,

    input  logic          c_cs,
    input  logic          c_we,
    input  logic [3:0]    c_ben,
    input  logic [AW-1:0] c_addr,
    input  logic [31:0]   c_wdata,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic [31:0]   c_rdata,

    input  logic          d_cs,
    input  logic          d_we,
    input  logic [3:0]    d_ben,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [31:0]   d_rdata,

    output logic          m_cs,
    output logic          m_we,
    output logic [3:0]    m_ben,
    output logic [AW-1:0] m_addr,
    output logic [31:0]   m_wdata,
    input  logic [31:0]   m_rdata
);

    if (MAX_WAIT == 0 || MAX_WAIT > 255) begin : g_bad_max_wait
        $error("dsram_arb: MAX_WAIT must be within 1..255");
    end

    logic force_d;
    logic rd_pend_q, rd_pend_d;
    logic rd_own_q,  rd_own_d;

    // Core wins unless D has been refused long enough to be forced through.
    always_comb begin
        c_gnt = c_cs & ~force_d;
        d_gnt = d_cs & (~c_cs | force_d);
    end

    // Memory port mux; idle fields are zeroed so the SRAM bus is quiet.
    always_comb begin
        m_cs    = c_gnt | d_gnt;
        m_we    = 1'b0;
        m_ben   = '0;
        m_addr  = '0;
        m_wdata = '0;
        if (c_gnt) begin
            m_we    = c_we;
            m_ben   = c_ben;
            m_addr  = c_addr;
            m_wdata = c_wdata;
        end else if (d_gnt) begin
            m_we    = d_we;
            m_ben   = d_ben;
            m_addr  = d_addr;
            m_wdata = d_wdata;
        end
    end

    // SRAM answers in order one cycle later, so a single owner bit suffices.
    always_comb begin
        rd_pend_d = m_cs & ~m_we;
        rd_own_d  = d_gnt;
    end

    always_ff @(posedge clk or negedge cpurst_n) begin
        if (!cpurst_n) begin
            rd_pend_q <= 1'b0;
            rd_own_q  <= 1'b0;
        end else begin
            rd_pend_q <= rd_pend_d;
            rd_own_q  <= rd_own_d;
        end
    end

    always_comb begin
        c_rvalid = rd_pend_q & ~rd_own_q;
        d_rvalid = rd_pend_q &  rd_own_q;
        c_rdata  = m_rdata;
        d_rdata  = m_rdata;
    end

`ifdef DSRAM_ARB_STARVE_EN
    localparam int unsigned CW = 8;

    logic [CW-1:0] wait_cnt_q, wait_cnt_d;

    // Counts consecutive refused cycles of a waiting D request, saturating.
    always_comb begin
        wait_cnt_d = '0;
        if (d_cs && !d_gnt) begin
            if (wait_cnt_q == {CW{1'b1}}) begin
                wait_cnt_d = wait_cnt_q;
            end else begin
                wait_cnt_d = wait_cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge cpurst_n) begin
        if (!cpurst_n) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign force_d = (wait_cnt_q >= CW'(MAX_WAIT));
`else
    assign force_d = 1'b0;
`endif

endmodule
